// File: rtl/rate_pkg.sv
// rate_pkg: shared definitions for the rate controller.
//   RATE_SLOW / RATE_MED / RATE_FAST : 2-bit RATE encodings (2'b11 unused)
//   state_t                          : controller FSM states
//   decode_sw()                      : fixed-priority switch decode
package rate_pkg;

  localparam logic [1:0] RATE_SLOW = 2'b00;
  localparam logic [1:0] RATE_MED  = 2'b01;
  localparam logic [1:0] RATE_FAST = 2'b10;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    LOAD
  } state_t;

  // SW2 > SW1 > SW0; no switch set falls back to MED.
  function automatic logic [1:0] decode_sw(input logic sw0,
                                           input logic sw1,
                                           input logic sw2);
    if (sw2)      return RATE_FAST;
    else if (sw1) return RATE_MED;
    else if (sw0) return RATE_SLOW;
    else          return RATE_MED;
  endfunction

endpackage

// File: rtl/sw_sync.sv
// sw_sync: synchronises the three rate-select switches, decodes them and
// (optionally) debounces the decoded request.
//   CLOCK         : sole clock, rising edge
//   RESET         : synchronous active-high reset
//   SW0, SW1, SW2 : asynchronous switch inputs
//   req           : accepted 2-bit rate request
// Macro RATE_CTRL_DEBOUNCE_EN: when defined, the decoded request is accepted
// only after it has been sampled unchanged for STABLE_CYC consecutive cycles;
// otherwise it is passed straight through after synchronisation.
module sw_sync
  import rate_pkg::*;
`ifdef RATE_CTRL_DEBOUNCE_EN
#(
  parameter int unsigned STABLE_CYC = 3
)
`endif
(
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  output logic [1:0] req
);

  logic [2:0] meta;
  logic [2:0] sync;
  logic [1:0] dec;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {SW2, SW1, SW0};
      sync <= meta;
    end
  end

  always_comb dec = decode_sw(sync[0], sync[1], sync[2]);

`ifdef RATE_CTRL_DEBOUNCE_EN
  localparam int unsigned   DW       = $clog2(STABLE_CYC + 1);
  localparam logic [DW-1:0] STABLE_V = DW'(STABLE_CYC);

  logic [1:0]    last;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_nxt;
  logic [1:0]    acc;

  // cnt holds how many consecutive samples of dec have been identical,
  // counting the current one; it saturates at STABLE_CYC.
  always_comb begin
    cnt_nxt = cnt;
    if (dec != last)
      cnt_nxt = DW'(1);
    else if (cnt != STABLE_V)
      cnt_nxt = cnt + 1'b1;
  end

  // acc starts at MED, which is what all-zero switches decode to, so leaving
  // reset never raises a spurious request.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      last <= '0;
      cnt  <= '0;
      acc  <= RATE_MED;
    end else begin
      last <= dec;
      cnt  <= cnt_nxt;
      if (cnt_nxt == STABLE_V)
        acc <= dec;
    end
  end

  assign req = acc;
`else
  assign req = dec;
`endif

endmodule

// File: rtl/rate_ctrl.sv
// rate_ctrl: tick generator with three switch-selectable rates and a
// glitch-free switchover.
//   CLOCK     : sole clock, rising edge
//   RESET     : synchronous active-high reset
//   SW0..SW2  : asynchronous rate-select switches (SW2 highest priority)
//   TICK      : one-cycle enable pulse at the current rate
//   RATE      : current rate, 00 SLOW / 01 MED / 10 FAST
//   SWITCHING : high while a rate change is pending or being loaded
// Macro RATE_CTRL_DEBOUNCE_EN enables the request debounce inside sw_sync.
module rate_ctrl
  import rate_pkg::*;
#(
  parameter int unsigned SLOW_DIV   = 8,
  parameter int unsigned MED_DIV    = 4,
  parameter int unsigned FAST_DIV   = 2,
  parameter int unsigned STABLE_CYC = 3
)(
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  output logic       TICK,
  output logic [1:0] RATE,
  output logic       SWITCHING
);

  localparam int unsigned MAX_DIV =
    (SLOW_DIV > MED_DIV) ? ((SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV)
                         : ((MED_DIV  > FAST_DIV) ? MED_DIV  : FAST_DIV);
  localparam int unsigned CW = $clog2(MAX_DIV);

  localparam logic [CW-1:0] SLOW_END = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0] MED_END  = CW'(MED_DIV - 1);
  localparam logic [CW-1:0] FAST_END = CW'(FAST_DIV - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    target;
  logic [1:0]    req;

  logic [CW-1:0] cur_end;
  logic [CW-1:0] cnt_run;
  logic          tick_run;
  logic [1:0]    new_tgt;

`ifdef RATE_CTRL_DEBOUNCE_EN
  sw_sync #(
    .STABLE_CYC (STABLE_CYC)
  ) u_sw_sync (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .SW0   (SW0),
    .SW1   (SW1),
    .SW2   (SW2),
    .req   (req)
  );
`else
  // Debounce is compiled out; STABLE_CYC stays for interface compatibility.
  localparam int unsigned stable_cyc_unused = STABLE_CYC;

  sw_sync u_sw_sync (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .SW0   (SW0),
    .SW1   (SW1),
    .SW2   (SW2),
    .req   (req)
  );
`endif

  function automatic logic [CW-1:0] end_of(input logic [1:0] r);
    case (r)
      RATE_SLOW: return SLOW_END;
      RATE_FAST: return FAST_END;
      default:   return MED_END;
    endcase
  endfunction

  // Free-running step of the period counter at the current rate; TICK is
  // registered, so it is set in the same edge that brings cnt to DIV-1.
  always_comb begin
    cur_end  = end_of(RATE);
    cnt_run  = (cnt == cur_end) ? '0 : cnt + 1'b1;
    tick_run = (cnt_run == cur_end);
    new_tgt  = (req != target) ? req : target;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= RUN;
      RATE      <= RATE_MED;
      TICK      <= 1'b0;
      SWITCHING <= 1'b0;
      cnt       <= '0;
      target    <= RATE_MED;
    end else begin
      case (state)
        RUN: begin
          cnt  <= cnt_run;
          TICK <= tick_run;
          if (req != RATE) begin
            state     <= PEND;
            target    <= req;
            SWITCHING <= 1'b1;
          end
        end

        PEND: begin
          // A withdrawn request wins over a simultaneous tick, so a change
          // that is cancelled in the tick cycle never reaches LOAD.
          if (req == RATE) begin
            state     <= RUN;
            SWITCHING <= 1'b0;
            cnt       <= cnt_run;
            TICK      <= tick_run;
          end else if (TICK) begin
            state  <= LOAD;
            RATE   <= new_tgt;
            target <= new_tgt;
            cnt    <= '0;
            TICK   <= 1'b0;
          end else begin
            target <= new_tgt;
            cnt    <= cnt_run;
            TICK   <= tick_run;
          end
        end

        LOAD: begin
          // Counter is held at 0 through LOAD so the first new-rate tick
          // lands a full new period after it.
          state     <= RUN;
          SWITCHING <= 1'b0;
          cnt       <= '0;
          TICK      <= 1'b0;
        end

        default: begin
          state     <= RUN;
          SWITCHING <= 1'b0;
          TICK      <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rate_ctrl.sv
// tb_rate_ctrl: directed self-checking bench for rate_ctrl with
// SLOW_DIV=8, MED_DIV=4, FAST_DIV=2, STABLE_CYC=3. Expectations follow the
// RATE_CTRL_DEBOUNCE_EN setting of the build.
module tb_rate_ctrl;

`ifdef RATE_CTRL_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int SW_LAT = 5;  // sampling edge -> SWITCHING: 2 sync + 3 stable
`else
  localparam bit DEB = 1'b0;
  localparam int SW_LAT = 2;  // sampling edge -> SWITCHING: 2 sync
`endif

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       SW0, SW1, SW2;
  logic       TICK;
  logic [1:0] RATE;
  logic       SWITCHING;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick = -1;
  int min_gap = 1000;

  rate_ctrl #(
    .SLOW_DIV   (8),
    .MED_DIV    (4),
    .FAST_DIV   (2),
    .STABLE_CYC (3)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .SW0       (SW0),
    .SW1       (SW1),
    .SW2       (SW2),
    .TICK      (TICK),
    .RATE      (RATE),
    .SWITCHING (SWITCHING)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Tracks the shortest spacing between consecutive ticks.
  always @(negedge CLOCK) begin
    if (RESET)
      last_tick = -1;
    else if (TICK) begin
      if (last_tick >= 0 && (cyc - last_tick) < min_gap)
        min_gap = cyc - last_tick;
      last_tick = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input string tag, input int limit);
    int k;
    k = 0;
    do begin
      step(1);
      k++;
    end while (TICK !== 1'b1 && k < limit);
    chk(tag, {7'd0, TICK}, 8'd1);
  endtask

  task automatic wait_rate(input string tag, input logic [1:0] r, input int limit);
    int k;
    k = 0;
    while (!(RATE === r && SWITCHING === 1'b0) && k < limit) begin
      step(1);
      k++;
    end
    chk({tag, "_rate"}, {6'd0, RATE}, {6'd0, r});
    chk({tag, "_sw"}, {7'd0, SWITCHING}, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    RESET = 1'b1;
    SW0 = 1'b0;
    SW1 = 1'b0;
    SW2 = 1'b0;

    // Reset state and MED cadence
    step(2);
    chk("rst_rate", {6'd0, RATE}, 8'h01);
    chk("rst_sw", {7'd0, SWITCHING}, 8'd0);
    chk("rst_tick", {7'd0, TICK}, 8'd0);
    RESET = 1'b0;
    step(2);
    chk("rel_tick_early", {7'd0, TICK}, 8'd0);
    step(1);
    chk("rel_tick_first", {7'd0, TICK}, 8'd1);
    step(3);
    chk("med_gap_lo", {7'd0, TICK}, 8'd0);
    step(1);
    chk("med_gap_hi", {7'd0, TICK}, 8'd1);

    // Two-cycle SW0 glitch while at MED
    SW0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (i == 2) SW0 = 1'b0;
      chk("pulse_sw", {7'd0, SWITCHING}, {7'd0, (!DEB && (i == 3 || i == 4))});
      chk("pulse_tick", {7'd0, TICK}, {7'd0, (i % 4 == 0)});
      chk("pulse_rate", {6'd0, RATE}, 8'h01);
    end

    // MED -> FAST via SW2
    SW2 = 1'b1;
    step(1);
    k = 0;
    while (SWITCHING !== 1'b1 && k < 20) begin
      step(1);
      k++;
    end
    chk("fast_sw_latency", k[7:0], SW_LAT[7:0]);
    chk("fast_pend_rate", {6'd0, RATE}, 8'h01);
    wait_tick("fast_old_tick", 8);
    chk("fast_old_tick_rate", {6'd0, RATE}, 8'h01);
    chk("fast_old_tick_sw", {7'd0, SWITCHING}, 8'd1);
    step(1);
    chk("load_rate", {6'd0, RATE}, 8'h02);
    chk("load_tick", {7'd0, TICK}, 8'd0);
    chk("load_sw", {7'd0, SWITCHING}, 8'd1);
    step(1);
    chk("post_load_tick", {7'd0, TICK}, 8'd0);
    chk("post_load_sw", {7'd0, SWITCHING}, 8'd0);
    step(1);
    chk("fast_tick1", {7'd0, TICK}, 8'd1);
    step(1);
    chk("fast_gap", {7'd0, TICK}, 8'd0);
    step(1);
    chk("fast_tick2", {7'd0, TICK}, 8'd1);

    // FAST -> SLOW
    SW2 = 1'b0;
    SW0 = 1'b1;
    wait_rate("to_slow", 2'b00, 40);

    // SW1 excursion inside one SLOW period
    wait_tick("slow_tick_a", 10);
    step(7);
    chk("slow_pre_tick", {7'd0, TICK}, 8'd0);
    SW1 = 1'b1;
    step(1);
    chk("slow_tick_b", {7'd0, TICK}, 8'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (i == 2) SW1 = 1'b0;
      chk("slow_glitch_sw", {7'd0, SWITCHING}, {7'd0, (i >= SW_LAT && i < SW_LAT + 3)});
      chk("slow_glitch_tick", {7'd0, TICK}, {7'd0, (i == 8)});
      chk("slow_glitch_rate", {6'd0, RATE}, 8'h00);
    end

    // All switches on from MED
    SW0 = 1'b0;
    wait_rate("to_med", 2'b01, 40);
    min_gap = 1000;
    SW0 = 1'b1;
    SW1 = 1'b1;
    SW2 = 1'b1;
    wait_rate("all_on", 2'b10, 40);
    step(6);
    chk("all_on_min_gap", min_gap[7:0], 8'd2);

    // Reset while pending toward FAST
    SW0 = 1'b0;
    SW1 = 1'b0;
    SW2 = 1'b0;
    wait_rate("pre_rst_med", 2'b01, 40);
    SW2 = 1'b1;
    k = 0;
    while (SWITCHING !== 1'b1 && k < 20) begin
      step(1);
      k++;
    end
    chk("pend_reached", {7'd0, SWITCHING}, 8'd1);
    RESET = 1'b1;
    SW2 = 1'b0;
    step(1);
    chk("abort_rate", {6'd0, RATE}, 8'h01);
    chk("abort_sw", {7'd0, SWITCHING}, 8'd0);
    chk("abort_tick", {7'd0, TICK}, 8'd0);
    RESET = 1'b0;
    step(2);
    chk("abort_tick_early", {7'd0, TICK}, 8'd0);
    step(1);
    chk("abort_tick_first", {7'd0, TICK}, 8'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("abort_after_sw", {7'd0, SWITCHING}, 8'd0);
      chk("abort_after_tick", {7'd0, TICK}, {7'd0, (i % 4 == 0)});
      chk("abort_after_rate", {6'd0, RATE}, 8'h01);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
